// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results satisfy dividend = quotient*divisor + remainder for any non-zero divisor.
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is accepted on a rising edge while busy=0 (IDLE or DONE);
  // done is a one-cycle pulse and the result outputs are valid in that cycle
  // and held until the next completion.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]  work_q, work_d;
  logic [DIVISOR_W-1:0]   dvsr_q, dvsr_d;
  logic [DIVISOR_W-1:0]   prem_q, prem_d;
  logic [DIVIDEND_W-1:0]  quot_q, quot_d;
  logic [DIVISOR_W-1:0]   rem_q, rem_d;
  logic                   dbz_q, dbz_d;

  logic [DIVISOR_W:0]     shifted;
  logic [DIVISOR_W-1:0]   diff;
  logic                   qbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // The dividend register shifts its MSB into the partial remainder while
    // quotient bits enter at its LSB, so after DIVIDEND_W steps it holds the quotient.
    shifted = {prem_q, work_q[DIVIDEND_W-1]};
    qbit    = (shifted >= {1'b0, dvsr_q});
    diff    = DIVISOR_W'(shifted - {1'b0, dvsr_q});

    case (state_q)
      S_RUN: begin
        if (dvsr_q == '0) begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          prem_d = qbit ? diff : shifted[DIVISOR_W-1:0];
          work_d = {work_q[DIVIDEND_W-2:0], qbit};
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            quot_d  = work_d;
            rem_d   = prem_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // IDLE and DONE both accept a new request; DONE acceptance gives back-to-back ops.
    if (state_q != S_RUN && start) begin
      work_d  = dividend;
      dvsr_d  = divisor;
      prem_d  = '0;
      cnt_d   = CNT_W'(DIVIDEND_W - 1);
      dbz_d   = 1'b0;
      state_d = S_RUN;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule
